// File: rtl/top_level_if.sv
// rtl/top_level_if.sv - req/ack start/done handshake between host and accelerator
interface top_level_if;
  logic req;
  logic ack;

  modport master (output req, input ack);
  modport slave  (input req, output ack);
endinterface

// File: rtl/top_level.sv
// rtl/top_level.sv - data-memory accelerator running Hamming encode, Hamming decode and 5-bit pattern count in turn
// One program per req; ack rises on completion and drops when the next req is taken.

module data_mem #(
  parameter int DEPTH = 256
) (
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o
);
  logic [7:0] core [0:DEPTH-1];

  always @(posedge clk_i) begin
    if (we_i) core[addr_i] <= wdata_i;
  end

  assign rdata_o = core[addr_i];
endmodule

module top_level #(
  parameter int MEM_DEPTH = 256,
  parameter int N_MSG     = 15
) (
  input  logic       clk,
  input  logic       reset,
  top_level_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [1:0] {P_ENC, P_DEC, P_CNT} prog_e;

  state_e      state_q, state_d;
  prog_e       sel_q, sel_d;
  prog_e       cur_q, cur_d;
  logic [1:0]  ph_q, ph_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] word_q, word_d;
  logic [4:0]  pat_q, pat_d;
  logic [7:0]  prev_q, prev_d;
  logic [7:0]  ctb_q, ctb_d;
  logic [7:0]  cto_q, cto_d;
  logic [7:0]  cts_q, cts_d;
  logic        ack_q, ack_d;

  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  msg_off;
  logic [7:0]  in_base;
  logic [7:0]  out_base;
  logic [15:0] window;
  logic [2:0]  byte_hits;
  logic [2:0]  cross_hits;
  logic        done_now;

  data_mem #(.DEPTH(MEM_DEPTH)) data_mem1 (
    .clk_i   (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  function automatic logic [15:0] ham_enc(input logic [11:1] d);
    logic p8, p4, p2, p1, p16;
    p8  = ^d[11:5];
    p4  = d[11] ^ d[10] ^ d[9] ^ d[8] ^ d[4] ^ d[3] ^ d[2];
    p2  = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1  = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p16 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p16};
  endfunction

  // Result is {F, 4'b0, d[11:9], d[8:1]}; w bit k holds Hamming position k.
  function automatic logic [15:0] ham_dec(input logic [15:0] w_in);
    logic [15:0] w;
    logic        p8, p4, p2, p1, q, f;
    logic [3:0]  s;
    w  = w_in;
    p8 = ^w[15:9];
    p4 = w[15] ^ w[14] ^ w[13] ^ w[12] ^ w[7] ^ w[6] ^ w[5];
    p2 = w[15] ^ w[14] ^ w[11] ^ w[10] ^ w[7] ^ w[6] ^ w[3];
    p1 = w[15] ^ w[13] ^ w[11] ^ w[9] ^ w[7] ^ w[5] ^ w[3];
    s  = {p8 ^ w[8], p4 ^ w[4], p2 ^ w[2], p1 ^ w[1]};
    q  = ^w;
    f  = (s != 4'd0) && !q;
    if ((s != 4'd0) && q) w[s] = ~w[s];
    return {f, 4'b0000, w[15:13], w[12:9], w[7:5], w[3]};
  endfunction

  assign msg_off  = {2'b00, idx_q, 1'b0};
  assign in_base  = (cur_q == P_ENC) ? 8'd0 : 8'd64;
  assign out_base = (cur_q == P_ENC) ? 8'd30 : 8'd94;
  assign window   = {prev_q, mem_rdata};
  assign bus.ack  = ack_q;

  // Windows ending at bits 0..3 lie inside the byte; 4..7 reach into the previous byte.
  always_comb begin
    byte_hits  = 3'd0;
    cross_hits = 3'd0;
    for (int e = 0; e < 4; e++) begin
      if (mem_rdata[e +: 5] == pat_q) byte_hits = byte_hits + 3'd1;
    end
    for (int e = 4; e < 8; e++) begin
      if (window[e +: 5] == pat_q) cross_hits = cross_hits + 3'd1;
    end
  end

  // Memory port: address/write strobe depend only on registered state.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 8'd0;
    mem_wdata = 8'd0;
    if (state_q == S_RUN) begin
      case (cur_q)
        P_ENC, P_DEC: begin
          case (ph_q)
            2'd0: mem_addr = in_base + msg_off;
            2'd1: mem_addr = in_base + msg_off + 8'd1;
            2'd2: begin
              mem_we    = reset;
              mem_addr  = out_base + msg_off;
              mem_wdata = word_q[7:0];
            end
            default: begin
              mem_we    = reset;
              mem_addr  = out_base + msg_off + 8'd1;
              mem_wdata = word_q[15:8];
            end
          endcase
        end
        P_CNT: begin
          case (ph_q)
            2'd0: mem_addr = 8'd160;
            2'd1: mem_addr = {3'b100, idx_q};
            default: begin
              mem_we    = reset;
              mem_addr  = 8'd192 + {3'b000, idx_q};
              mem_wdata = (idx_q == 5'd0) ? ctb_q : ((idx_q == 5'd1) ? cto_q : cts_q);
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cur_d    = cur_q;
    ph_d     = ph_q;
    idx_d    = idx_q;
    lo_d     = lo_q;
    word_d   = word_q;
    pat_d    = pat_q;
    prev_d   = prev_q;
    ctb_d    = ctb_q;
    cto_d    = cto_q;
    cts_d    = cts_q;
    ack_d    = ack_q;
    done_now = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.req) begin
          ack_d   = 1'b0;
          state_d = S_RUN;
          cur_d   = sel_q;
          ph_d    = 2'd0;
          idx_d   = 5'd0;
          prev_d  = 8'd0;
          ctb_d   = 8'd0;
          cto_d   = 8'd0;
          cts_d   = 8'd0;
          case (sel_q)
            P_ENC:   sel_d = P_DEC;
            P_DEC:   sel_d = P_CNT;
            default: sel_d = P_ENC;
          endcase
        end
      end
      S_RUN: begin
        case (cur_q)
          P_ENC, P_DEC: begin
            case (ph_q)
              2'd0: begin
                lo_d = mem_rdata;
                ph_d = 2'd1;
              end
              2'd1: begin
                word_d = (cur_q == P_ENC) ? ham_enc({mem_rdata[2:0], lo_q})
                                          : ham_dec({mem_rdata, lo_q});
                ph_d   = 2'd2;
              end
              2'd2: ph_d = 2'd3;
              default: begin
                if (idx_q == 5'(N_MSG - 1)) begin
                  done_now = 1'b1;
                end else begin
                  idx_d = idx_q + 5'd1;
                  ph_d  = 2'd0;
                end
              end
            endcase
          end
          P_CNT: begin
            case (ph_q)
              2'd0: begin
                pat_d = mem_rdata[4:0];
                ph_d  = 2'd1;
              end
              2'd1: begin
                ctb_d  = ctb_q + {5'b00000, byte_hits};
                cto_d  = cto_q + {7'b0000000, |byte_hits};
                cts_d  = cts_q + {5'b00000, byte_hits}
                       + ((idx_q != 5'd0) ? {5'b00000, cross_hits} : 8'd0);
                prev_d = mem_rdata;
                if (idx_q == 5'd31) begin
                  idx_d = 5'd0;
                  ph_d  = 2'd2;
                end else begin
                  idx_d = idx_q + 5'd1;
                end
              end
              default: begin
                if (idx_q == 5'd2) done_now = 1'b1;
                else idx_d = idx_q + 5'd1;
              end
            endcase
          end
          default: done_now = 1'b1;
        endcase
        if (done_now) begin
          state_d = S_DONE;
          ack_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sel_q   <= P_ENC;
      cur_q   <= P_ENC;
      ph_q    <= 2'd0;
      idx_q   <= 5'd0;
      lo_q    <= 8'd0;
      word_q  <= 16'd0;
      pat_q   <= 5'd0;
      prev_q  <= 8'd0;
      ctb_q   <= 8'd0;
      cto_q   <= 8'd0;
      cts_q   <= 8'd0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cur_q   <= cur_d;
      ph_q    <= ph_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      word_q  <= word_d;
      pat_q   <= pat_d;
      prev_q  <= prev_d;
      ctb_q   <= ctb_d;
      cto_q   <= cto_d;
      cts_q   <= cts_d;
      ack_q   <= ack_d;
    end
  end
endmodule

// File: tb/tb_top_level.sv
// tb/tb_top_level.sv - randomized self-checking bench for top_level against a positional Hamming / bit-string model
module tb_top_level;
  logic clk;
  logic reset;
  top_level_if bus ();

  top_level #(.MEM_DEPTH(256), .N_MSG(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  int          checks;
  int          errors;
  logic [7:0]  mm [0:255];
  logic [10:0] dlist [15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] m_encode(input logic [10:0] d);
    logic [15:0] w;
    logic [3:0]  syn;
    w = '0;
    for (int j = 0; j < 11; j++) w[DPOS[j]] = d[j];
    syn = '0;
    for (int k = 1; k < 16; k++) if (w[k]) syn = syn ^ 4'(k);
    w[1] = syn[0];
    w[2] = syn[1];
    w[4] = syn[2];
    w[8] = syn[3];
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [15:0] m_decode(input logic [15:0] win);
    logic [15:0] w;
    logic [3:0]  syn;
    logic [10:0] d;
    logic        f;
    w   = win;
    syn = '0;
    for (int k = 1; k < 16; k++) if (w[k]) syn = syn ^ 4'(k);
    f = 1'b0;
    if (syn != 4'd0) begin
      if (^w) w[syn] = ~w[syn];
      else f = 1'b1;
    end
    for (int j = 0; j < 11; j++) d[j] = w[DPOS[j]];
    return {f, 4'b0000, d};
  endfunction

  task automatic fill_random();
    for (int a = 0; a < 256; a++) mm[a] = 8'($urandom);
  endtask

  task automatic load_dut();
    for (int a = 0; a < 256; a++) dut.data_mem1.core[a] = mm[a];
  endtask

  task automatic model_p1();
    logic [15:0] w;
    for (int i = 0; i < 15; i++) begin
      w = m_encode({mm[2*i+1][2:0], mm[2*i]});
      mm[30+2*i] = w[7:0];
      mm[31+2*i] = w[15:8];
    end
  endtask

  task automatic model_p2();
    logic [15:0] r;
    for (int i = 0; i < 15; i++) begin
      r = m_decode({mm[65+2*i], mm[64+2*i]});
      mm[94+2*i] = r[7:0];
      mm[95+2*i] = r[15:8];
    end
  endtask

  task automatic model_p3();
    logic       s [256];
    logic [4:0] pat;
    logic [4:0] v;
    logic [7:0] b;
    int         ctb, cto, cts, hit;
    pat = mm[160][4:0];
    for (int j = 0; j < 32; j++)
      for (int t = 0; t < 8; t++) s[8*j+t] = mm[128+j][7-t];
    ctb = 0;
    cto = 0;
    cts = 0;
    for (int p = 0; p < 252; p++) begin
      v = '0;
      for (int t = 0; t < 5; t++) v = {v[3:0], s[p+t]};
      if (v == pat) cts++;
    end
    for (int j = 0; j < 32; j++) begin
      b   = mm[128+j];
      hit = 0;
      for (int sh = 0; sh < 4; sh++) if (5'(b >> sh) == pat) hit++;
      ctb += hit;
      if (hit > 0) cto++;
    end
    mm[192] = 8'(ctb);
    mm[193] = 8'(cto);
    mm[194] = 8'(cts);
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 256; a++) begin
      checks++;
      if (dut.data_mem1.core[a] !== mm[a]) begin
        errors++;
        $display("FAIL %s mem[%0d] got %h expected %h", tag, a, dut.data_mem1.core[a], mm[a]);
      end
    end
  endtask

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    while (bus.ack !== 1'b1 && n < 2048) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.ack !== 1'b1) begin
      errors++;
      $display("FAIL %s ack_timeout got %b expected 1 within 2048 clk", tag, bus.ack);
    end
  endtask

  task automatic start_and_wait(input string tag);
    @(negedge clk);
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    checks++;
    if (bus.ack !== 1'b0) begin
      errors++;
      $display("FAIL %s ack_clear got %b expected 0", tag, bus.ack);
    end
    wait_ack(tag);
  endtask

  task automatic test_reset();
    bus.req = 1'b0;
    reset   = 1'b0;
    fill_random();
    load_dut();
    @(negedge clk);
    for (int a = 200; a < 204; a++) begin
      mm[a] = 8'($urandom);
      dut.data_mem1.core[a] = mm[a];
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack got %b expected 0", bus.ack);
    end
    check_mem("reset_mem");
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_p1_basic();
    fill_random();
    mm[0] = 8'hFF;
    mm[1] = 8'h07;
    mm[2] = 8'h00;
    mm[3] = 8'h00;
    load_dut();
    model_p1();
    start_and_wait("p1_basic");
    checks += 4;
    if (dut.data_mem1.core[31] !== 8'hFF || dut.data_mem1.core[30] !== 8'hFF) begin
      errors++;
      $display("FAIL p1_ones got %h%h expected ffff", dut.data_mem1.core[31], dut.data_mem1.core[30]);
    end
    if (dut.data_mem1.core[33] !== 8'h00 || dut.data_mem1.core[32] !== 8'h00) begin
      errors++;
      $display("FAIL p1_zeros got %h%h expected 0000", dut.data_mem1.core[33], dut.data_mem1.core[32]);
    end
    if (dut.data_mem1.core[29] !== mm[29]) begin
      errors++;
      $display("FAIL p1_input_kept got %h expected %h", dut.data_mem1.core[29], mm[29]);
    end
    if (dut.data_mem1.core[60] !== mm[60]) begin
      errors++;
      $display("FAIL p1_above_kept got %h expected %h", dut.data_mem1.core[60], mm[60]);
    end
    check_mem("p1_basic");
  endtask

  task automatic test_handshake_p2();
    logic [15:0] w;
    int          n;
    fill_random();
    for (int i = 0; i < 15; i++) begin
      dlist[i] = 11'($urandom);
      w = m_encode(dlist[i]) ^ (16'h0001 << i);
      mm[64+2*i] = w[7:0];
      mm[65+2*i] = w[15:8];
    end
    load_dut();
    model_p2();
    @(negedge clk);
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    checks++;
    if (bus.ack !== 1'b0) begin
      errors++;
      $display("FAIL hs_ack_drop got %b expected 0", bus.ack);
    end
    n = 0;
    while (bus.ack !== 1'b1 && n < 2048) begin
      bus.req = (n == 5);
      @(negedge clk);
      n++;
    end
    bus.req = 1'b0;
    checks++;
    if (bus.ack !== 1'b1) begin
      errors++;
      $display("FAIL hs_timeout got %b expected 1", bus.ack);
    end
    check_mem("hs_p2");
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (dut.data_mem1.core[94+2*i] !== dlist[i][7:0] ||
          dut.data_mem1.core[95+2*i] !== {5'b00000, dlist[i][10:8]}) begin
        errors++;
        $display("FAIL p2_single_k%0d got %h%h expected %h", i, dut.data_mem1.core[95+2*i],
                 dut.data_mem1.core[94+2*i], {5'b00000, dlist[i]});
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ack !== 1'b1) begin
      errors++;
      $display("FAIL hs_ack_hold got %b expected 1", bus.ack);
    end
  endtask

  task automatic test_p3_fixed(input string tag, input logic [7:0] fill, input logic [4:0] pat,
                               input int e_ctb, input int e_cto, input int e_cts);
    fill_random();
    for (int j = 128; j < 160; j++) mm[j] = fill;
    mm[160] = {3'($urandom), pat};
    load_dut();
    model_p3();
    start_and_wait(tag);
    checks++;
    if (dut.data_mem1.core[192] !== 8'(e_ctb) || dut.data_mem1.core[193] !== 8'(e_cto) ||
        dut.data_mem1.core[194] !== 8'(e_cts)) begin
      errors++;
      $display("FAIL %s counts got %0d,%0d,%0d expected %0d,%0d,%0d", tag, dut.data_mem1.core[192],
               dut.data_mem1.core[193], dut.data_mem1.core[194], e_ctb, e_cto, e_cts);
    end
    check_mem(tag);
  endtask

  task automatic test_p1_random(input string tag);
    fill_random();
    load_dut();
    model_p1();
    start_and_wait(tag);
    check_mem(tag);
  endtask

  task automatic test_p2_random(input string tag);
    logic [15:0] w;
    int          a, b;
    fill_random();
    for (int i = 0; i < 15; i++) begin
      w = m_encode(11'($urandom));
      a = $urandom_range(15, 0);
      b = (a + $urandom_range(15, 1)) % 16;
      if (i == 0) w[15] = ~w[15];
      else case ($urandom_range(2, 0))
        0: ;
        1: w[a] = ~w[a];
        default: begin
          w[a] = ~w[a];
          w[b] = ~w[b];
        end
      endcase
      mm[64+2*i] = w[7:0];
      mm[65+2*i] = w[15:8];
    end
    load_dut();
    model_p2();
    start_and_wait(tag);
    check_mem(tag);
  endtask

  task automatic test_p3_random(input string tag);
    logic [4:0] pat;
    fill_random();
    pat = 5'($urandom);
    mm[160] = {3'($urandom), pat};
    for (int j = 128; j < 160; j++)
      if ($urandom_range(1, 0) == 1) mm[j] = {3'($urandom), pat} << $urandom_range(3, 0);
    load_dut();
    model_p3();
    start_and_wait(tag);
    check_mem(tag);
  endtask

  task automatic test_abort();
    fill_random();
    load_dut();
    model_p1();
    @(negedge clk);
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.ack !== 1'b0) begin
      errors++;
      $display("FAIL abort_ack got %b expected 0", bus.ack);
    end
    reset = 1'b1;
    @(negedge clk);
    start_and_wait("abort_p1");
    check_mem("abort_p1");
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    bus.req = 1'b0;
    reset   = 1'b0;
    test_reset();
    test_p1_basic();
    test_handshake_p2();
    test_p3_fixed("p3_zero", 8'h00, 5'b00000, 128, 32, 252);
    test_p1_random("p1_wrap");
    test_p2_random("p2_rand_a");
    test_p3_fixed("p3_55", 8'h55, 5'b10101, 64, 32, 126);
    test_abort();
    test_p2_random("p2_rand_b");
    test_p3_random("p3_rand");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
